regfile_dump_engine: RTL and testbench
======================================

Name: regfile_dump_engine

Overview:
Sequencer that owns the read and write port of a 1r1w register file while active. It serves two jobs:
- Dump: walks an address range and streams each entry out over a val/rdy response interface.
- Clear: walks an address range and writes zero to each entry.

It is used for debug/trace readout and bulk initialisation of processor register-file state, and sits beside the register file in front of its ports.

Parameters:
p_data_nbits, 32, width of one register-file entry
p_num_entries, 32, number of register-file entries (any value >= 2, not necessarily a power of two)
c_addr_nbits, $clog2(p_num_entries), local address width, not set from outside

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_val  input  1  request valid
req_rdy  output  1  request ready
req_type  input  1  0 = dump, 1 = clear
req_first  input  c_addr_nbits  first address of range (inclusive)
req_last  input  c_addr_nbits  last address of range (inclusive)
rf_read_addr  output  c_addr_nbits  register-file read address
rf_read_data  input  p_data_nbits  register-file read data (combinational read)
rf_write_en  output  1  register-file write enable
rf_write_addr  output  c_addr_nbits  register-file write address
rf_write_data  output  p_data_nbits  register-file write data
resp_val  output  1  response valid
resp_rdy  input  1  response ready
resp_addr  output  c_addr_nbits  address of returned entry
resp_data  output  p_data_nbits  data of returned entry
resp_last  output  1  final response of a request
resp_err  output  1  request rejected (range out of bounds)
busy  output  1  engine owns the register-file ports

Behaviour:
Reset:
- State goes to IDLE.
- Outputs after reset: req_rdy=1, resp_val=0, rf_write_en=0, busy=0; resp_addr, resp_data, resp_last, resp_err, rf_read_addr and rf_write_addr all 0.
- Reset asserted mid-operation aborts immediately: the next cycle is IDLE, and no further writes or responses occur.

States: IDLE, DUMP, CLEAR, DONE, ERR.

IDLE:
- req_rdy=1, busy=0.
- A request transfers when req_val && req_rdy. The operands are latched into first/last/cursor registers (cursor = req_first).
- If req_first >= p_num_entries or req_last >= p_num_entries, go to ERR. Otherwise go to DUMP when req_type=0, or CLEAR when req_type=1.

DUMP:
- busy=1, rf_read_addr=cursor, resp_val=1.
- resp_addr=cursor, resp_data=rf_read_data (combinational pass-through), resp_last=(cursor==last), resp_err=0.
- On resp_val && resp_rdy: if cursor==last, go to IDLE; otherwise advance cursor.
- While resp_rdy=0, the cursor holds and the outputs stay stable.
- First response is valid 1 cycle after the request transfer.

CLEAR:
- busy=1, rf_write_en=1, rf_write_addr=cursor, rf_write_data=0.
- One entry is written per cycle with no stall. After writing last, go to DONE.

DONE:
- resp_val=1, resp_addr=last, resp_data=0, resp_last=1, resp_err=0.
- Go to IDLE on resp_rdy.

ERR:
- busy=1, resp_val=1, resp_err=1, resp_last=1, resp_addr=0, resp_data=0.
- Go to IDLE on resp_rdy.
- No register-file access occurs.

Cursor advance:
- cursor = (cursor == p_num_entries-1) ? 0 : cursor+1.
- This explicit wrap is required for non-power-of-two sizes.
- first > last is legal and wraps through p_num_entries-1 to 0.
- first == last touches exactly one entry.
- Total entries touched = ((last - first) mod p_num_entries) + 1.

General rules:
- req_rdy=0 in every state except IDLE.
- rf_write_en=0 in every state except CLEAR.
- rf_read_addr=cursor while busy.
- resp_val is never asserted in IDLE or CLEAR.
- A request and the final response handshake can never coincide in the same cycle; the engine returns to IDLE first, so back-to-back requests have 1 idle cycle between them.

Test Plan:
- Preload entries 0..31 with 0x100+i, dump first=3, last=6, resp_rdy=1 -> 4 responses on consecutive cycles: (3,0x103), (4,0x104), (5,0x105), (6,0x106,last=1); then req_rdy=1.
- Dump first=30, last=1 on a 32-entry file -> responses at addresses 30, 31, 0, 1 in that order, last=1 only on address 1.
- Dump first=last=5 with resp_rdy toggling 0,0,1 -> resp_val held 3 cycles with stable (5,0x105,last=1); exactly one transfer.
- Clear first=0, last=31 -> 32 consecutive cycles of rf_write_en=1 with addresses 0..31 and data 0, then one DONE response (addr 31, last=1); a subsequent full dump returns all zeros.
- p_num_entries=24: request with last=24 -> single response err=1, last=1, no rf_write_en pulse. Dump first=22, last=0 -> responses at 22, 23, 0.
- Assert reset during the 3rd cycle of a 32-entry clear -> only entries first..first+1 are written; the cycle after reset shows req_rdy=1, busy=0, resp_val=0, rf_write_en=0.

Source files
------------

// File: rtl/regfile_dump_engine.sv
// regfile_dump_engine: owns the 1r1w register-file ports while active.
// Dump streams an inclusive, wrapping address range out over val/rdy.
// Clear writes zero to every entry of an inclusive, wrapping range.
module regfile_dump_engine #(
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 32,
    localparam int c_addr_nbits = $clog2(p_num_entries)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_val,
    output logic                    req_rdy,
    input  logic                    req_type,
    input  logic [c_addr_nbits-1:0] req_first,
    input  logic [c_addr_nbits-1:0] req_last,
    output logic [c_addr_nbits-1:0] rf_read_addr,
    input  logic [p_data_nbits-1:0] rf_read_data,
    output logic                    rf_write_en,
    output logic [c_addr_nbits-1:0] rf_write_addr,
    output logic [p_data_nbits-1:0] rf_write_data,
    output logic                    resp_val,
    input  logic                    resp_rdy,
    output logic [c_addr_nbits-1:0] resp_addr,
    output logic [p_data_nbits-1:0] resp_data,
    output logic                    resp_last,
    output logic                    resp_err,
    output logic                    busy
);

    // One extra bit so the bounds check is meaningful when p_num_entries is a power of two
    localparam logic [c_addr_nbits:0]   c_num_entries = (c_addr_nbits + 1)'(p_num_entries);
    localparam logic [c_addr_nbits-1:0] c_max_addr    = c_addr_nbits'(p_num_entries - 1);

    typedef enum logic [2:0] {
        IDLE,
        DUMP,
        CLEAR,
        DONE,
        ERR
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [c_addr_nbits-1:0] cursor;
    logic [c_addr_nbits-1:0] last;
    logic [c_addr_nbits-1:0] cursor_inc;
    logic                    at_last;
    logic                    range_bad;

    assign cursor_inc = (cursor == c_max_addr) ? '0 : cursor + c_addr_nbits'(1);
    assign at_last    = (cursor == last);
    assign range_bad  = ({1'b0, req_first} >= c_num_entries) ||
                        ({1'b0, req_last}  >= c_num_entries);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Range registers: latch operands on request transfer, advance cursor per entry handled
    always_ff @(posedge clk) begin
        if (reset) begin
            cursor <= '0;
            last   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val) begin
                        cursor <= req_first;
                        last   <= req_last;
                    end
                end
                DUMP: begin
                    if (resp_rdy && !at_last) begin
                        cursor <= cursor_inc;
                    end
                end
                CLEAR: begin
                    if (!at_last) begin
                        cursor <= cursor_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_val) begin
                    if (range_bad) begin
                        state_next = ERR;
                    end else if (req_type) begin
                        state_next = CLEAR;
                    end else begin
                        state_next = DUMP;
                    end
                end
            end
            DUMP: begin
                if (resp_rdy && at_last) begin
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (at_last) begin
                    state_next = DONE;
                end
            end
            DONE, ERR: begin
                if (resp_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_rdy       = 1'b0;
        busy          = 1'b1;
        rf_read_addr  = cursor;
        rf_write_en   = 1'b0;
        rf_write_addr = '0;
        rf_write_data = '0;
        resp_val      = 1'b0;
        resp_addr     = '0;
        resp_data     = '0;
        resp_last     = 1'b0;
        resp_err      = 1'b0;
        case (state)
            IDLE: begin
                req_rdy      = 1'b1;
                busy         = 1'b0;
                rf_read_addr = '0;
            end
            DUMP: begin
                resp_val  = 1'b1;
                resp_addr = cursor;
                resp_data = rf_read_data;
                resp_last = at_last;
            end
            CLEAR: begin
                rf_write_en   = 1'b1;
                rf_write_addr = cursor;
            end
            DONE: begin
                resp_val  = 1'b1;
                resp_addr = last;
                resp_last = 1'b1;
            end
            ERR: begin
                resp_val  = 1'b1;
                resp_last = 1'b1;
                resp_err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Directed bench for regfile_dump_engine: a 32-entry instance backed by a
// register-file model, and a 24-entry instance for non-power-of-two wrap and bounds.
module tb_regfile_dump_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // ---------------- 32-entry instance ----------------
    logic        reset;
    logic        req_val, req_rdy, req_type;
    logic [4:0]  req_first, req_last;
    logic [4:0]  rf_read_addr, rf_write_addr, resp_addr;
    logic [31:0] rf_read_data, rf_write_data, resp_data;
    logic        rf_write_en, resp_val, resp_rdy, resp_last, resp_err, busy;

    regfile_dump_engine #(.p_data_nbits(32), .p_num_entries(32)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
        .req_first(req_first), .req_last(req_last),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_addr(resp_addr), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err), .busy(busy)
    );

    // Register-file model; preload fills entry i with 0x100+i
    logic [31:0] rf [32];
    logic        preload;
    logic [31:0] gold [32];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + 32'(i);
        end else if (rf_write_en) begin
            rf[rf_write_addr] <= rf_write_data;
        end
    end
    assign rf_read_data = rf[rf_read_addr];

    // ---------------- 24-entry instance ----------------
    logic        b_req_val, b_req_rdy, b_req_type;
    logic [4:0]  b_req_first, b_req_last;
    logic [4:0]  b_rf_read_addr, b_rf_write_addr, b_resp_addr;
    logic [31:0] b_rf_read_data, b_rf_write_data, b_resp_data;
    logic        b_rf_write_en, b_resp_val, b_resp_rdy, b_resp_last, b_resp_err, b_busy;
    int          b_we_count = 0;

    regfile_dump_engine #(.p_data_nbits(32), .p_num_entries(24)) dut24 (
        .clk(clk), .reset(reset),
        .req_val(b_req_val), .req_rdy(b_req_rdy), .req_type(b_req_type),
        .req_first(b_req_first), .req_last(b_req_last),
        .rf_read_addr(b_rf_read_addr), .rf_read_data(b_rf_read_data),
        .rf_write_en(b_rf_write_en), .rf_write_addr(b_rf_write_addr), .rf_write_data(b_rf_write_data),
        .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_addr(b_resp_addr), .resp_data(b_resp_data),
        .resp_last(b_resp_last), .resp_err(b_resp_err), .busy(b_busy)
    );

    assign b_rf_read_data = 32'h200 + {27'd0, b_rf_read_addr};
    always @(posedge clk) if (b_rf_write_en) b_we_count <= b_we_count + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req_rdy"}, 64'(req_rdy), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_resp_val"}, 64'(resp_val), 64'd0);
        check({tag, "_we"}, 64'(rf_write_en), 64'd0);
    endtask

    // Issue a dump with resp_rdy=1 and check every response against the gold copy
    task automatic run_dump(input int first, input int last, input string tag);
        int n;
        int a;
        n = ((last - first + 32) % 32) + 1;
        req_val = 1'b1; req_type = 1'b0;
        req_first = 5'(first); req_last = 5'(last); resp_rdy = 1'b1;
        tick();
        req_val = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = (first + i) % 32;
            check({tag, "_val"}, 64'(resp_val), 64'd1);
            check({tag, "_addr"}, 64'(resp_addr), 64'(a));
            check({tag, "_data"}, 64'(resp_data), 64'(gold[a]));
            check({tag, "_last"}, 64'(resp_last), 64'(i == n - 1));
            check({tag, "_req_rdy"}, 64'(req_rdy), 64'd0);
            tick();
        end
        check_idle({tag, "_end"});
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1;
        req_val = 1'b0; req_type = 1'b0; req_first = '0; req_last = '0; resp_rdy = 1'b0;
        b_req_val = 1'b0; b_req_type = 1'b0; b_req_first = '0; b_req_last = '0; b_resp_rdy = 1'b0;
        for (int i = 0; i < 32; i++) gold[i] = 32'h100 + 32'(i);
        tick(); tick();
        reset = 1'b0; preload = 1'b0;

        // Reset state
        check_idle("rst");
        check("rst_resp_addr", 64'(resp_addr), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_resp_last", 64'(resp_last), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_rd_addr", 64'(rf_read_addr), 64'd0);
        check("rst_wr_addr", 64'(rf_write_addr), 64'd0);

        // Simple dump, then wrapping dump
        run_dump(3, 6, "dump3_6");
        run_dump(30, 1, "dump30_1");

        // Single-entry dump with two stall cycles
        req_val = 1'b1; req_type = 1'b0; req_first = 5'd5; req_last = 5'd5; resp_rdy = 1'b0;
        tick();
        req_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) resp_rdy = 1'b1;
            #1;
            check("stall_val", 64'(resp_val), 64'd1);
            check("stall_addr", 64'(resp_addr), 64'd5);
            check("stall_data", 64'(resp_data), 64'h105);
            check("stall_last", 64'(resp_last), 64'd1);
            tick();
        end
        check_idle("stall_end");

        // Full clear
        req_val = 1'b1; req_type = 1'b1; req_first = 5'd0; req_last = 5'd31; resp_rdy = 1'b0;
        tick();
        req_val = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("clr_we", 64'(rf_write_en), 64'd1);
            check("clr_waddr", 64'(rf_write_addr), 64'(i));
            check("clr_wdata", 64'(rf_write_data), 64'd0);
            check("clr_resp_val", 64'(resp_val), 64'd0);
            tick();
        end
        check("done_val", 64'(resp_val), 64'd1);
        check("done_addr", 64'(resp_addr), 64'd31);
        check("done_last", 64'(resp_last), 64'd1);
        check("done_err", 64'(resp_err), 64'd0);
        check("done_data", 64'(resp_data), 64'd0);
        check("done_we", 64'(rf_write_en), 64'd0);
        tick();
        check("done_hold", 64'(resp_val), 64'd1);
        resp_rdy = 1'b1;
        tick();
        check_idle("done_end");
        for (int i = 0; i < 32; i++) gold[i] = 32'd0;
        run_dump(0, 31, "dump_zero");

        // Reset in the middle of a wrapping clear 10..9
        preload = 1'b1;
        tick();
        preload = 1'b0;
        for (int i = 0; i < 32; i++) gold[i] = 32'h100 + 32'(i);
        req_val = 1'b1; req_type = 1'b1; req_first = 5'd10; req_last = 5'd9;
        tick();
        req_val = 1'b0;
        check("abort_waddr0", 64'(rf_write_addr), 64'd10);
        tick();
        check("abort_waddr1", 64'(rf_write_addr), 64'd11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("abort");
        tick();
        check("abort_still_idle", 64'(rf_write_en), 64'd0);
        gold[10] = 32'd0; gold[11] = 32'd0;
        run_dump(9, 13, "dump_abort");

        // 24-entry: out-of-range clear request is rejected without writes
        b_req_val = 1'b1; b_req_type = 1'b1; b_req_first = 5'd0; b_req_last = 5'd24; b_resp_rdy = 1'b1;
        tick();
        b_req_val = 1'b0;
        check("err_val", 64'(b_resp_val), 64'd1);
        check("err_err", 64'(b_resp_err), 64'd1);
        check("err_last", 64'(b_resp_last), 64'd1);
        check("err_addr", 64'(b_resp_addr), 64'd0);
        check("err_data", 64'(b_resp_data), 64'd0);
        check("err_busy", 64'(b_busy), 64'd1);
        check("err_req_rdy", 64'(b_req_rdy), 64'd0);
        tick();
        check("err_idle", 64'(b_req_rdy), 64'd1);
        check("err_no_write", 64'(b_we_count), 64'd0);

        // 24-entry: dump 22..0 wraps at 23
        b_req_val = 1'b1; b_req_type = 1'b0; b_req_first = 5'd22; b_req_last = 5'd0;
        tick();
        b_req_val = 1'b0;
        check("w24_addr0", 64'(b_resp_addr), 64'd22);
        check("w24_data0", 64'(b_resp_data), 64'h216);
        check("w24_last0", 64'(b_resp_last), 64'd0);
        tick();
        check("w24_addr1", 64'(b_resp_addr), 64'd23);
        check("w24_data1", 64'(b_resp_data), 64'h217);
        tick();
        check("w24_addr2", 64'(b_resp_addr), 64'd0);
        check("w24_data2", 64'(b_resp_data), 64'h200);
        check("w24_last2", 64'(b_resp_last), 64'd1);
        tick();
        check("w24_idle", 64'(b_resp_val), 64'd0);
        check("w24_no_write", 64'(b_we_count), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
